// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and arbitration state encoding for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector of pending long-latency destinations with RAW/WAW hazard lookup.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              sb_set,
    input  logic [REG_AW-1:0] sb_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              hazard
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            rs1_busy;
    logic            rs2_busy;

    // Clear is applied before set so a same-cycle set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (sb_set) begin
            busy_next[sb_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Source reads see a same-cycle B write through register-file forwarding; WAW does not.
    assign rs1_busy = busy[chk_rs1] && !(clr_en && (clr_rd == chk_rs1));
    assign rs2_busy = busy[chk_rs2] && !(clr_en && (clr_rd == chk_rs2));
    assign hazard   = rs1_busy || rs2_busy || busy[chk_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file write-port arbiter with anti-starvation and B-unit scoreboard.
// Optional statistics counters are built when RF_WB_STATS_EN is defined.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_data,
    input  logic              sb_set,
    input  logic [REG_AW-1:0] sb_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              hazard,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata
`ifdef RF_WB_STATS_EN
    ,
    output logic [15:0]       stat_conflicts,
    output logic [15:0]       stat_forced
`endif
);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             grant_a;
    logic             grant_b;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= PRIO_A;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        case (state)
            PRIO_A: begin
                if (a_valid) begin
                    grant_a = 1'b1;
                    if (b_valid) begin
                        starve_next = starve_cnt + 1'b1;
                        if (starve_cnt == CNT_W'(STARVE_MAX - 1)) begin
                            state_next = PRIO_B;
                        end
                    end
                end else if (b_valid) begin
                    grant_b     = 1'b1;
                    starve_next = '0;
                end
            end
            PRIO_B: begin
                starve_next = '0;
                state_next  = PRIO_A;
                if (b_valid) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = a_valid;
                end
            end
            default: begin
                state_next = PRIO_A;
            end
        endcase
        // While in reset the A path stays live but B can never complete.
        if (!Reset) begin
            grant_b = 1'b0;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign rf_we    = grant_b ? (b_rd != '0) : (grant_a && (a_rd != '0));
    assign rf_rd    = grant_b ? b_rd : a_rd;
    assign rf_wdata = grant_b ? b_data : a_data;

    rf_scoreboard u_scoreboard (
        .CLK     (CLK),
        .Reset   (Reset),
        .sb_set  (sb_set),
        .sb_rd   (sb_rd),
        .clr_en  (grant_b),
        .clr_rd  (b_rd),
        .chk_rs1 (chk_rs1),
        .chk_rs2 (chk_rs2),
        .chk_rd  (chk_rd),
        .hazard  (hazard)
    );

`ifdef RF_WB_STATS_EN
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stat_conflicts <= '0;
            stat_forced    <= '0;
        end else begin
            if (a_valid && b_valid && (stat_conflicts != 16'hFFFF)) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
            if ((state == PRIO_B) && grant_b && (stat_forced != 16'hFFFF)) begin
                stat_forced <= stat_forced + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed literal checks plus randomized model comparison.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int SM = 4;

    logic              CLK = 1'b0;
    logic              Reset = 1'b0;
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic [REG_AW-1:0] a_rd = '0;
    logic [XLEN-1:0]   a_data = '0;
    logic              b_valid = 1'b0;
    logic              b_ready;
    logic [REG_AW-1:0] b_rd = '0;
    logic [XLEN-1:0]   b_data = '0;
    logic              sb_set = 1'b0;
    logic [REG_AW-1:0] sb_rd = '0;
    logic [REG_AW-1:0] chk_rs1 = '0;
    logic [REG_AW-1:0] chk_rs2 = '0;
    logic [REG_AW-1:0] chk_rd = '0;
    logic              hazard;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;
`ifdef RF_WB_STATS_EN
    logic [15:0]       stat_conflicts;
    logic [15:0]       stat_forced;
`endif

    rf_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_rd     (a_rd),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_rd     (b_rd),
        .b_data   (b_data),
        .sb_set   (sb_set),
        .sb_rd    (sb_rd),
        .chk_rs1  (chk_rs1),
        .chk_rs2  (chk_rs2),
        .chk_rd   (chk_rd),
        .hazard   (hazard),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_wdata (rf_wdata)
`ifdef RF_WB_STATS_EN
        ,
        .stat_conflicts (stat_conflicts),
        .stat_forced    (stat_forced)
`endif
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: consecutive B losses, whether B is owed the next grant, pending destinations.
    int losses;
    bit owed;
    bit sb_model [NREG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        losses = 0;
        owed   = 1'b0;
        for (int i = 0; i < NREG; i++) sb_model[i] = 1'b0;
    endtask

    function automatic logic [REG_AW-1:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return REG_AW'($urandom_range(0, NREG - 1));
        return REG_AW'($urandom_range(0, 7));
    endfunction

    task automatic idle_inputs();
        a_valid = 1'b0; b_valid = 1'b0; sb_set = 1'b0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    task automatic random_phase(input int ncyc);
        bit gb, ga, exp_we, exp_hz;
        logic [REG_AW-1:0] exp_rd;
        logic [XLEN-1:0]   exp_data;
        bit a_done, b_done;
        a_done = 1'b1;
        b_done = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (a_done) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_rd    = rnd_reg();
                a_data  = $urandom;
            end
            if (b_done) begin
                b_valid = ($urandom_range(0, 99) < 45);
                b_rd    = rnd_reg();
                b_data  = $urandom;
            end
            sb_set  = ($urandom_range(0, 99) < 30);
            sb_rd   = rnd_reg();
            chk_rs1 = rnd_reg();
            chk_rs2 = rnd_reg();
            chk_rd  = rnd_reg();
            #3;
            gb       = b_valid && (owed || !a_valid);
            ga       = a_valid && !gb;
            exp_we   = (ga && a_rd != 0) || (gb && b_rd != 0);
            exp_rd   = gb ? b_rd : a_rd;
            exp_data = gb ? b_data : a_data;
            exp_hz   = (sb_model[chk_rs1] && !(gb && b_rd == chk_rs1)) ||
                       (sb_model[chk_rs2] && !(gb && b_rd == chk_rs2)) ||
                       sb_model[chk_rd];
            check("rnd a_ready", a_ready, ga);
            check("rnd b_ready", b_ready, gb);
            check("rnd rf_we", rf_we, exp_we);
            check("rnd rf_rd", rf_rd, exp_rd);
            check("rnd rf_wdata", rf_wdata, exp_data);
            check("rnd hazard", hazard, exp_hz);
            a_done = !a_valid || a_ready;
            b_done = !b_valid || b_ready;
            if (gb) begin
                losses = 0;
                owed   = 1'b0;
            end else if (a_valid && b_valid) begin
                losses++;
                if (losses >= SM) owed = 1'b1;
            end else if (owed) begin
                owed   = 1'b0;
                losses = 0;
            end
            if (gb && b_rd != 0) sb_model[b_rd] = 1'b0;
            if (sb_set && sb_rd != 0) sb_model[sb_rd] = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        // Reset state and combinational behaviour while in reset.
        #2;
        check("rst b_ready", b_ready, 1'b0);
        check("rst hazard", hazard, 1'b0);
        check("rst rf_we", rf_we, 1'b0);
        a_valid = 1'b1; a_rd = 5'd5; b_valid = 1'b1; b_rd = 5'd6;
        #1;
        check("rst a_ready", a_ready, 1'b1);
        check("rst rf_we A", rf_we, 1'b1);
        check("rst b_ready held", b_ready, 1'b0);
        idle_inputs();
        @(negedge CLK);
        Reset = 1'b1;
        tick();

        // A-only writes, including the x0 case.
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
        #2;
        check("A a_ready", a_ready, 1'b1);
        check("A rf_we", rf_we, 1'b1);
        check("A rf_rd", rf_rd, 5'd5);
        check("A rf_wdata", rf_wdata, 32'h1234);
        tick();
        a_rd = 5'd0;
        #2;
        check("A x0 a_ready", a_ready, 1'b1);
        check("A x0 rf_we", rf_we, 1'b0);
        tick();

        // Six conflict cycles: B forced through on the fifth.
        for (int c = 0; c < 6; c++) begin
            a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA0 + c;
            b_valid = 1'b1; b_rd = 5'd3; b_data = 32'hB0 + c;
            #2;
            check("starve b_ready", b_ready, (c == 4));
            check("starve a_ready", a_ready, (c != 4));
            check("starve rf_wdata", rf_wdata, (c == 4) ? 32'hB4 : 32'hA0 + c);
            tick();
        end
        idle_inputs();
        tick();

        // Scoreboard set, forwarded clear and WAW.
        sb_set = 1'b1; sb_rd = 5'd7; chk_rs1 = 5'd7;
        #2;
        check("sb pre-set hazard", hazard, 1'b0);
        tick();
        sb_set = 1'b0;
        #2;
        check("sb set hazard", hazard, 1'b1);
        tick();
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
        #2;
        check("sb clr b_ready", b_ready, 1'b1);
        check("sb fwd hazard rs1", hazard, 1'b0);
        chk_rd = 5'd7;
        #1;
        check("sb waw hazard rd", hazard, 1'b1);
        tick();
        b_valid = 1'b0; chk_rd = 5'd0;
        #2;
        check("sb cleared hazard", hazard, 1'b0);
        tick();

        // Same-cycle set and clear of r9: set wins.
        sb_set = 1'b1; sb_rd = 5'd9; b_valid = 1'b1; b_rd = 5'd9;
        tick();
        sb_set = 1'b0; b_valid = 1'b0; chk_rs1 = 5'd9;
        #2;
        check("sb set wins", hazard, 1'b1);
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0; chk_rd = 5'd9;
        #2;
        check("sb r9 cleared", hazard, 1'b0);
        tick();
        chk_rs1 = 5'd0; chk_rd = 5'd0;
        sb_set = 1'b1; sb_rd = 5'd0;
        tick();
        sb_set = 1'b0;
        #2;
        check("sb x0 never set", hazard, 1'b0);
        tick();

        // Reset while in PRIO_B with r3 pending.
        sb_set = 1'b1; sb_rd = 5'd3;
        tick();
        sb_set = 1'b0;
        for (int c = 0; c < SM; c++) begin
            a_valid = 1'b1; a_rd = 5'd2; b_valid = 1'b1; b_rd = 5'd12;
            #2;
            check("pre-force b_ready", b_ready, 1'b0);
            tick();
        end
        chk_rs1 = 5'd3;
        #2;
        check("forced b_ready", b_ready, 1'b1);
        check("forced hazard", hazard, 1'b1);
        #1;
        Reset = 1'b0;
        #1;
        check("mid-rst b_ready", b_ready, 1'b0);
        check("mid-rst a_ready", a_ready, 1'b1);
        check("mid-rst hazard", hazard, 1'b0);
        check("mid-rst rf_we", rf_we, 1'b1);
        a_valid = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        check("post-rst lone B", b_ready, 1'b1);
        tick();
        b_valid = 1'b0;
        #2;
        check("post-rst sb empty", hazard, 1'b0);

        // Resynchronise and run randomized traffic against the model.
        idle_inputs();
        Reset = 1'b0;
        model_reset();
        @(negedge CLK);
        Reset = 1'b1;
        random_phase(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
